// File: rtl/spi_master_driver.sv
// ============================================================================
// Module   : spi_master_driver
// Brief    : SPI master issuing 10-bit command frames (MSB first) on the
//            shared system clock; read-data frames capture an 8-bit reply
//            from MISO after RD_LAT cycles of turnaround.
// Option   : SPI_MASTER_PROTO_CHK_EN - reject read-data commands that are
//            not preceded by a read-address command (pulses err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_driver #(
  parameter int RD_LAT = 3,
  parameter int GAP    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_word,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  // One shared wait counter covers both the read turnaround and the gap.
  localparam int c_wait_max = (RD_LAT > GAP) ? RD_LAT : GAP;
  localparam int c_wait_w   = (c_wait_max > 2) ? $clog2(c_wait_max) : 1;
  localparam logic [c_wait_w-1:0] c_rd_last  = c_wait_w'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  // SS_n is already high during the frame-ending edge, so GAP-1 more cycles.
  localparam logic [c_wait_w-1:0] c_gap_last = c_wait_w'((GAP > 1) ? GAP - 2 : 0);
  localparam logic [1:0] c_op_rd_addr = 2'b10;
  localparam logic [1:0] c_op_rd_data = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_WAIT_RD = 3'd3,
    S_CAPTURE = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t                r_state;
  logic [9:0]            r_sh;
  logic                  r_rd;
  logic [3:0]            r_bit_cnt;
  logic [c_wait_w-1:0]   r_wait_cnt;
`ifdef SPI_MASTER_PROTO_CHK_EN
  logic                  r_rd_armed;
  logic                  r_reject;
`else
  assign err = 1'b0;
`endif

  // Frame sequencer: all pin and handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sh       <= '0;
      r_rd       <= 1'b0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      SS_n       <= 1'b1;
      MOSI       <= 1'b0;
`ifdef SPI_MASTER_PROTO_CHK_EN
      err        <= 1'b0;
      r_rd_armed <= 1'b0;
      r_reject   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef SPI_MASTER_PROTO_CHK_EN
      err       <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_sh       <= cmd_word;
            r_rd       <= (cmd_word[9:8] == c_op_rd_data);
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            r_state    <= S_HOLD;
`ifdef SPI_MASTER_PROTO_CHK_EN
            if (cmd_word[9:8] == c_op_rd_data && !r_rd_armed) begin
              r_reject <= 1'b1;
            end else begin
              r_reject <= 1'b0;
              SS_n     <= 1'b0;
              MOSI     <= cmd_word[9];
              if (cmd_word[9:8] == c_op_rd_addr)      r_rd_armed <= 1'b1;
              else if (cmd_word[9:8] == c_op_rd_data) r_rd_armed <= 1'b0;
            end
`else
            SS_n <= 1'b0;
            MOSI <= cmd_word[9];
`endif
          end
        end

        S_HOLD: begin
`ifdef SPI_MASTER_PROTO_CHK_EN
          if (r_reject) begin
            err       <= 1'b1;
            r_reject  <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end else
`endif
          if (r_bit_cnt == 4'd1) begin
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end

        S_SHIFT: begin
          if (r_bit_cnt == 4'd9) begin
            MOSI       <= 1'b0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            if (r_rd) begin
              r_state <= (RD_LAT > 0) ? S_WAIT_RD : S_CAPTURE;
            end else begin
              SS_n <= 1'b1;
              if (GAP > 1) begin
                r_state <= S_GAP;
              end else begin
                r_state   <= S_IDLE;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
              end
            end
          end else begin
            MOSI      <= r_sh[8];
            r_sh      <= {r_sh[8:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end

        S_WAIT_RD: begin
          if (r_wait_cnt == c_rd_last) begin
            r_wait_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= S_CAPTURE;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
          end
        end

        S_CAPTURE: begin
          if (r_bit_cnt == 4'd8) begin
            rsp_valid  <= 1'b1;
            SS_n       <= 1'b1;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            if (GAP > 1) begin
              r_state <= S_GAP;
            end else begin
              r_state   <= S_IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            rsp_data  <= {rsp_data[6:0], MISO};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end

        S_GAP: begin
          if (r_wait_cnt == c_gap_last) begin
            r_wait_cnt <= '0;
            r_state    <= S_IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
          end
        end

        default: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          SS_n      <= 1'b1;
          MOSI      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_driver.sv
// ============================================================================
// Module   : tb_spi_master_driver
// Brief    : Self-checking bench for spi_master_driver; directed frames then
//            randomized commands/resets against a frame-timing reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master_driver;

  localparam int RD_LAT = 3;
  localparam int GAP    = 2;
  localparam int L_WR   = 12;
  localparam int L_RD   = 21 + RD_LAT;
  localparam int N_CYC  = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_word = '0;
  logic       miso = 1'b0;
  logic       cmd_ready, rsp_valid, busy, err, ss_n, mosi;
  logic [7:0] rsp_data;

  spi_master_driver #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .err(err), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = -1;

  // Reference model: one active frame described by its accept edge and kind.
  bit         frame_on = 0;
  bit         f_rd = 0;
  bit         f_rej = 0;
  int         f_len = 0;
  int         a_edge = 0;
  logic [9:0] f_word = '0;
  logic [7:0] f_byte = '0;
  logic [7:0] last_byte = '0;
  int         ready_edge = 0;
  bit         armed = 0;
  bit         want_mid_reset = 0;
  bit         from_q = 0;
  logic [9:0] q[$];
  int         q_idx = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected MOSI at offset t from the accept edge while SS_n is low.
  function automatic logic exp_mosi_at(input int t, input logic [9:0] w);
    if (t < 0 || t > 11) return 1'b0;
    if (t <= 2) return w[9];
    return w[11 - t];
  endfunction

  initial begin
    int  t, tn;
    bit  exp_low, exp_rdy, exp_rv, exp_err;
    q.push_back(10'b11_0000_0000);  // read-data straight after reset
    q.push_back(10'b00_1010_0101);  // write
    q.push_back(10'b10_0000_1111);  // read-address
    q.push_back(10'b11_0000_0000);  // read-data, slave returns C3
    q.push_back(10'b01_1100_0011);  // write, reset at A+6
    q.push_back(10'b00_0101_1010);  // clean write after reset
    q.push_back(10'b01_1111_0000);  // back-to-back writes
    q.push_back(10'b00_0000_1111);

    for (int i = 0; i < N_CYC; i++) begin
      @(negedge clk);
      // ---- drive inputs for edge cyc+1 ----
      rst_n = 1'b1;
      if (i < 3) rst_n = 1'b0;
      if (want_mid_reset && frame_on && (cyc + 1 - a_edge) == 6) begin
        rst_n = 1'b0;
        want_mid_reset = 0;
      end
      if (q.size() == 0 && $urandom_range(0, 399) == 0) rst_n = 1'b0;
      if (q.size() != 0) begin
        cmd_valid = 1'b1;
        cmd_word  = q[0];
        from_q    = 1;
      end else begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_word  = 10'($urandom);
        from_q    = 0;
      end
      tn = cyc + 1 - a_edge;
      if (frame_on && f_rd && !f_rej && tn >= 13 + RD_LAT && tn <= 20 + RD_LAT)
        miso = f_byte[20 + RD_LAT - tn];
      else
        miso = 1'($urandom);

      @(posedge clk);
      cyc = cyc + 1;
      // ---- model update at this edge ----
      if (!rst_n) begin
        frame_on   = 0;
        ready_edge = cyc + 1;
        armed      = 0;
        last_byte  = '0;
      end else if (cmd_valid && cyc >= ready_edge) begin
        frame_on = 1;
        a_edge   = cyc;
        f_word   = cmd_word;
        f_rd     = (cmd_word[9:8] == 2'b11);
        f_rej    = 0;
`ifdef SPI_MASTER_PROTO_CHK_EN
        if (f_rd && !armed) f_rej = 1;
        if (!f_rej) begin
          if (cmd_word[9:8] == 2'b10) armed = 1;
          if (cmd_word[9:8] == 2'b11) armed = 0;
        end
`endif
        f_len      = f_rej ? 0 : (f_rd ? L_RD : L_WR);
        ready_edge = f_rej ? cyc + 2 : cyc + f_len + GAP;
        f_byte     = from_q ? 8'hC3 : 8'($urandom);
        if (from_q) begin
          void'(q.pop_front());
          q_idx++;
          if (q_idx == 5) want_mid_reset = 1;
        end
      end

      #1;
      // ---- compare DUT against model ----
      t       = cyc - a_edge;
      exp_low = frame_on && !f_rej && t < f_len;
      exp_rdy = (cyc + 1 >= ready_edge);
      exp_rv  = frame_on && f_rd && !f_rej && t == f_len;
      exp_err = frame_on && f_rej && t == 1;
      if (exp_rv) last_byte = f_byte;
      check_eq("ss_n", ss_n, !exp_low);
      check_eq("mosi", mosi, exp_low ? exp_mosi_at(t, f_word) : 1'b0);
      check_eq("cmd_ready", cmd_ready, exp_rdy);
      check_eq("busy", busy, !exp_rdy);
      check_eq("rsp_valid", rsp_valid, exp_rv);
      check_eq("err", err, exp_err);
      if (exp_rv || exp_rdy) check_eq("rsp_data", rsp_data, last_byte);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_master_driver.md
# spi_master_driver

Synchronous SPI master that produces 10-bit command frames for the team's SPI slave and, for read-data commands, captures the 8-bit byte the slave returns on MISO. It sits between a host-side command/response handshake and the slave's `SS_n`/`MOSI`/`MISO` pins. The master shares the slave's `clk`; there is no separate SCLK.

## Interface
- `RD_LAT`, default 3: clock cycles between the last MOSI bit being sampled by the slave and the first valid MISO bit.
- `GAP`, default 2: minimum number of cycles `SS_n` stays high between frames.
---
- `clk`  in  1  system and SPI clock; all logic on posedge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  high in IDLE; a command is accepted on a clk edge where `cmd_valid && cmd_ready`.
- `cmd_word`  in  10  frame payload sent MSB first. Bits [9:8] are the opcode: 00/01 write, 10 read-address, 11 read-data.
- `rsp_valid`  out  1  one-cycle pulse when `rsp_data` is valid.
- `rsp_data`  out  8  byte captured from MISO.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle protocol-error pulse; see Configuration.
- `SS_n`  out  1  slave select, active-low, registered.
- `MOSI`  out  1  serial data to the slave, registered.
- `MISO`  in  1  serial data from the slave.

## Operation
- Reset values:
  - `SS_n`=1, `MOSI`=0, `rsp_valid`=0, `rsp_data`=0, `err`=0, `busy`=0.
  - `cmd_ready`=1 from the first cycle after reset.
  - State is IDLE.
- States: IDLE, HOLD, SHIFT, WAIT_RD, CAPTURE, GAP.
- **IDLE**
  - On accept, latch `cmd_word` into `sh[9:0]`, drive `SS_n`<=0 and `MOSI`<=`cmd_word[9]`, then go to HOLD.
- **HOLD**
  - Lasts 3 cycles, counting the accept edge.
  - `MOSI` stays at bit 9. This covers the slave's IDLE→CHK_CMD decode and its first shift.
- **SHIFT**
  - Drives bits 8..0 on successive edges, one per cycle.
  - Bit 0 is held until the slave samples it.
  - For opcodes 00, 01 and 10: at the next edge `SS_n`<=1 and `MOSI`<=0, then go to GAP.
  - For opcode 11: `SS_n` stays low, `MOSI`<=0, then go to WAIT_RD.
- **WAIT_RD**
  - Counts `RD_LAT` cycles with `SS_n` still low.
- **CAPTURE**
  - Samples `MISO` on 8 consecutive edges, MSB first, into `rsp_data`.
  - On the edge after the 8th sample: `rsp_valid`=1 for one cycle, `SS_n`<=1, then go to GAP.
- **GAP**
  - `SS_n` stays high for `GAP` cycles, then go to IDLE.
- Counters:
  - A 4-bit bit counter and a counter sized for `RD_LAT`.
  - Both are cleared on every state entry.
  - Neither wraps within a frame.
- `cmd_valid` outside IDLE is ignored and not queued.
- Reset mid-frame aborts at once:
  - `SS_n`=1 on the next edge.
  - No `rsp_valid` is issued.
  - The partial `rsp_data` is cleared to 0.

## Timing
- Let A be the accept edge.
- Edge A: `SS_n` falls and `MOSI`=bit9.
- `MOSI` changes to bit k (k = 8..0) at edge A+11−k; bit0 is driven at A+11.
- Write or read-address frame:
  - `SS_n` rises at A+12.
  - `cmd_ready` returns at A+12+`GAP`.
  - Total frame: 12 low cycles.
- Read-data frame:
  - MISO is sampled at edges A+12+`RD_LAT`+1 through A+12+`RD_LAT`+8.
  - `rsp_valid` and the `SS_n` rise occur at A+12+`RD_LAT`+9.
- Back-to-back commands:
  - Minimum command period is 12+`GAP` cycles.
  - For read-data it is 21+`RD_LAT`+`GAP` cycles.
- `cmd_valid` is sampled only at edges where `cmd_ready`=1.

## Configuration
- Macro: `SPI_MASTER_PROTO_CHK_EN`.
- **Defined:**
  - The master tracks a flag that is set by an issued read-address command and cleared by an issued read-data command.
  - A read-data command accepted while the flag is 0 is not transmitted: `SS_n` stays high, `err` pulses for one cycle at A+1, and the state returns to IDLE with `cmd_ready` high at A+1.
  - Consecutive read-address commands are legal.
  - The flag clears on reset.
- **Undefined:**
  - Every opcode is transmitted.
  - `err` is tied to 0.
  - The flag logic is absent.

## Test plan
- Reset held for 3 cycles, then released → `SS_n`=1, `MOSI`=0, `cmd_ready`=1, `rsp_valid`=0.
- Write `cmd_word`=10'b00_1010_0101 → `SS_n` low from A to A+12; MOSI sequence 0,0,0 then 0,1,0,1,0,0,1,0,1; `cmd_ready` returns at A+14.
- Read-address 10'b10_0000_1111, then read-data 10'b11_0000_0000, with the slave model returning 8'hC3 after `RD_LAT`=3 → `rsp_valid` at A+24 with `rsp_data`=8'hC3; `SS_n` low for 24 cycles.
- Reset asserted at A+6 of a write → `SS_n`=1 on the next edge, no `rsp_valid`, clean frame on the next command.
- With `SPI_MASTER_PROTO_CHK_EN`, read-data issued right after reset → `err`=1 at A+1, `SS_n` never falls. Without the macro the same stimulus gives a normal 24-cycle frame and `err`=0.
- `cmd_valid` held high continuously with writes → accepts spaced exactly 14 cycles apart; no accept occurs while `busy`=1.
